// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - opcode, ALU, immediate and state encodings for the multi-cycle RV32I control unit
package mcpu_pkg;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0000;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_I    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_U    = 3'b101;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
  } op_class_e;

  // ADD is forced for address/PC arithmetic; R and I follow Fun3/Fun7.
  typedef enum logic [1:0] {ALU_CLS_ADD, ALU_CLS_R, ALU_CLS_I} alu_cls_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_R:      return CL_R;
      OP_I:      return CL_I;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      OP_JAL:    return CL_JAL;
      OP_JALR:   return CL_JALR;
      OP_LUI:    return CL_LUI;
      OP_AUIPC:  return CL_AUIPC;
      default:   return CL_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel(input op_class_e cls);
    case (cls)
      CL_I, CL_LOAD, CL_JALR: return IMM_I;
      CL_STORE:               return IMM_S;
      CL_BRANCH:              return IMM_B;
      CL_JAL:                 return IMM_J;
      CL_LUI, CL_AUIPC:       return IMM_U;
      default:                return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_alu_decode.sv
// rtl/mcpu_alu_decode.sv - {class,Fun3,Fun7} to ALU_Control, shared with the single-cycle core
module mcpu_alu_decode
  import mcpu_pkg::*;
(
  input  logic [1:0] cls_i,
  input  logic [2:0] fun3_i,
  input  logic       fun7_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    if (cls_i != ALU_CLS_ADD) begin
      case (fun3_i)
        // Immediate ops have no SUBI, so Fun7 only selects SUB for register ops.
        3'b000:  alu_ctrl_o = (cls_i == ALU_CLS_R && fun7_i) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl_o = ALU_SLL;
        3'b010:  alu_ctrl_o = ALU_SLT;
        3'b011:  alu_ctrl_o = ALU_SLTU;
        3'b100:  alu_ctrl_o = ALU_XOR;
        3'b101:  alu_ctrl_o = fun7_i ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl_o = ALU_OR;
        default: alu_ctrl_o = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// rtl/mcpu_ctrl_fsm.sv - multi-cycle RV32I control FSM with bus timeout, illegal trap and instret
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       OPcode,
  input  logic [2:0]       Fun3,
  input  logic             Fun7,
  input  logic             MIO_ready,
  input  logic             cmp_taken,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             IRWrite,
  output logic             IorD,
  output logic             CPU_MIO,
  output logic             MemRW,
  output logic [1:0]       ALUSrc_A,
  output logic [1:0]       ALUSrc_B,
  output logic [2:0]       ImmSel,
  output logic [3:0]       ALU_Control,
  output logic             RegWrite,
  output logic [1:0]       MemtoReg,
  output logic             trap,
  output logic             trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              trap_q, cause_q;
  logic [CNT_W-1:0]  instret_q;

  op_class_e  cls;
  logic [1:0] alu_cls;
  logic [3:0] alu_ctrl;
  logic       mem_phase;
  logic       timeout;
  logic       illegal;

  assign cls       = op_class(OPcode);
  assign mem_phase = (state_q == S_IF) || (state_q == S_MEM);
  assign timeout   = (MEM_TIMEOUT != 0) && mem_phase && !MIO_ready &&
                     (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  // Fun3 010/011 have no branch comparator meaning.
  assign illegal   = (cls == CL_ILLEGAL) || (cls == CL_BRANCH && Fun3[2:1] == 2'b01);

  always_comb begin
    alu_cls = ALU_CLS_ADD;
    if (state_q == S_EX && cls == CL_R)      alu_cls = ALU_CLS_R;
    else if (state_q == S_EX && cls == CL_I) alu_cls = ALU_CLS_I;
  end

  mcpu_alu_decode u_alu_decode (
    .cls_i      (alu_cls),
    .fun3_i     (Fun3),
    .fun7_i     (Fun7),
    .alu_ctrl_o (alu_ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (MIO_ready)    state_d = S_ID;
        else if (timeout) state_d = S_TRAP;
      end
      S_ID: state_d = illegal ? S_TRAP : S_EX;
      S_EX: begin
        case (cls)
          CL_R, CL_I, CL_AUIPC: state_d = S_WB;
          CL_LOAD, CL_STORE:    state_d = S_MEM;
          default:              state_d = S_IF;
        endcase
      end
      S_MEM: begin
        if (MIO_ready)    state_d = (cls == CL_LOAD) ? S_WB : S_IF;
        else if (timeout) state_d = S_TRAP;
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (mem_phase && !MIO_ready && state_d == state_q) wait_q <= wait_q + 1'b1;
      else                                               wait_q <= '0;
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= mem_phase;
      end
      if (state_d == S_IF && (state_q == S_EX || state_q == S_MEM || state_q == S_WB))
        instret_q <= instret_q + 1'b1;
    end
  end

  // Reset forces every output low immediately, aborting any bus access in flight.
  always_comb begin
    PCWrite     = 1'b0;
    PCSource    = 2'b00;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    CPU_MIO     = 1'b0;
    MemRW       = 1'b0;
    ALUSrc_A    = 2'b00;
    ALUSrc_B    = 2'b00;
    ImmSel      = IMM_NONE;
    ALU_Control = 4'b0000;
    RegWrite    = 1'b0;
    MemtoReg    = 2'b00;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          CPU_MIO     = 1'b1;
          ALUSrc_A    = 2'b01;
          ALUSrc_B    = 2'b01;
          ALU_Control = alu_ctrl;
          if (MIO_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_ID: begin
          ALUSrc_A    = 2'b10;
          ALUSrc_B    = 2'b10;
          ImmSel      = imm_sel(cls);
          ALU_Control = alu_ctrl;
        end
        S_EX: begin
          ImmSel = imm_sel(cls);
          case (cls)
            CL_R: ALU_Control = alu_ctrl;
            CL_I, CL_LOAD, CL_STORE: begin
              ALUSrc_B    = 2'b10;
              ALU_Control = alu_ctrl;
            end
            CL_BRANCH: begin
              if (cmp_taken) begin
                PCWrite  = 1'b1;
                PCSource = 2'b01;
              end
            end
            CL_JAL: begin
              RegWrite = 1'b1;
              MemtoReg = 2'b10;
              PCWrite  = 1'b1;
              PCSource = 2'b01;
            end
            CL_JALR: begin
              ALUSrc_B    = 2'b10;
              ALU_Control = alu_ctrl;
              PCWrite     = 1'b1;
              PCSource    = 2'b10;
              RegWrite    = 1'b1;
              MemtoReg    = 2'b10;
            end
            CL_LUI: begin
              RegWrite = 1'b1;
              MemtoReg = 2'b11;
            end
            CL_AUIPC: begin
              ALUSrc_A    = 2'b10;
              ALUSrc_B    = 2'b10;
              ALU_Control = alu_ctrl;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          CPU_MIO = 1'b1;
          IorD    = 1'b1;
          MemRW   = (cls == CL_STORE);
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls == CL_LOAD) ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// tb/tb_mcpu_ctrl_fsm.sv - scoreboard bench for the multi-cycle control FSM
module tb_mcpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  OPcode;
  logic [2:0]  Fun3;
  logic        Fun7, MIO_ready, cmp_taken;
  logic        PCWrite, IRWrite, IorD, CPU_MIO, MemRW, RegWrite, trap, trap_cause;
  logic [1:0]  PCSource, ALUSrc_A, ALUSrc_B, MemtoReg;
  logic [2:0]  ImmSel;
  logic [3:0]  ALU_Control;
  logic [31:0] instret;
  logic [20:0] ctl;

  mcpu_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
    .MIO_ready(MIO_ready), .cmp_taken(cmp_taken), .PCWrite(PCWrite), .PCSource(PCSource),
    .IRWrite(IRWrite), .IorD(IorD), .CPU_MIO(CPU_MIO), .MemRW(MemRW), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .ImmSel(ImmSel), .ALU_Control(ALU_Control), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  assign ctl = {PCWrite, PCSource, IRWrite, IorD, CPU_MIO, MemRW, ALUSrc_A, ALUSrc_B,
                ImmSel, ALU_Control, RegWrite, MemtoReg};

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] alu;
    int         cyc;
    int         rw;
    logic [1:0] m2r;
    logic [2:0] imm;
    bit         is_store;
    bit         is_br;
    logic       pcw;
    logic [1:0] pcs;
  } ins_t;

  exp_t        sb_q[$];
  ins_t        tbl[21];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_left;
  bit          stuck;
  logic [31:0] exp_instret;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb_q.push_back('{tag, v});
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    check_value("sb_depth_nonzero", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_value(e.tag, obs, e.val);
    end
  endtask

  // Memory handshake: ready in IF unless stuck; MEM holds off for wait_left cycles.
  task automatic cycle_drive(output bit in_mem);
    @(negedge clk);
    #1;
    in_mem = CPU_MIO && IorD;
    if (stuck) MIO_ready = 1'b0;
    else if (in_mem && wait_left > 0) begin
      MIO_ready = 1'b0;
      wait_left--;
    end else MIO_ready = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    MIO_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_instret = 0;
  endtask

  task automatic run_instr(input ins_t t, input logic cmp, input int waits);
    int          cyc = 0, rw = 0, mw = 0;
    logic [1:0]  m2r = 0, pcs = 0;
    logic [3:0]  alu = 0;
    logic [2:0]  imm = 0;
    logic        pcw = 0;
    logic [31:0] i0;
    bit          done = 0, m;
    OPcode = t.op; Fun3 = t.f3; Fun7 = t.f7; cmp_taken = cmp; wait_left = waits;
    exp_instret++;
    push_exp({t.name, ".cycles"}, t.cyc + ((t.is_store || t.m2r == 2'b01) ? waits : 0));
    push_exp({t.name, ".regwrite_cnt"}, t.rw);
    push_exp({t.name, ".memtoreg"}, t.m2r);
    push_exp({t.name, ".memrw_cnt"}, t.is_store ? 1 + waits : 0);
    push_exp({t.name, ".immsel_id"}, t.imm);
    push_exp({t.name, ".alu_ex"}, t.alu);
    push_exp({t.name, ".pcwrite_ex"}, t.is_br ? cmp : t.pcw);
    push_exp({t.name, ".pcsource_ex"}, t.is_br ? (cmp ? 2'b01 : 2'b00) : t.pcs);
    push_exp({t.name, ".instret"}, exp_instret);
    i0 = instret;
    while (!done && cyc < 40) begin
      cycle_drive(m);
      if (RegWrite) begin rw++; m2r = MemtoReg; end
      if (MemRW) mw++;
      if (cyc == 1) imm = ImmSel;
      if (cyc == 2) begin alu = ALU_Control; pcw = PCWrite; pcs = PCSource; end
      cyc++;
      @(posedge clk);
      #1;
      if (instret != i0) done = 1;
    end
    pop_cmp(cyc); pop_cmp(rw); pop_cmp(m2r); pop_cmp(mw); pop_cmp(imm);
    pop_cmp(alu); pop_cmp(pcw); pop_cmp(pcs); pop_cmp(instret);
  endtask

  task automatic run_illegal(input string name, input logic [4:0] op, input logic [2:0] f3);
    bit m;
    OPcode = op; Fun3 = f3; Fun7 = 1'b0; wait_left = 0;
    cycle_drive(m);
    @(posedge clk);
    cycle_drive(m);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      cycle_drive(m);
      push_exp({name, ".trap"}, 1);       pop_cmp(trap);
      push_exp({name, ".cause"}, 0);      pop_cmp(trap_cause);
      push_exp({name, ".ctl_quiet"}, 0);  pop_cmp(ctl);
      @(posedge clk);
    end
    push_exp({name, ".instret"}, exp_instret); pop_cmp(instret);
    do_reset();
    #1;
    push_exp({name, ".trap_cleared"}, 0); pop_cmp(trap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, n, w;
    bit m;
    tbl[0]  = '{"add",   5'b01100, 3'b000, 1'b0, 4'b0010, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[1]  = '{"sub",   5'b01100, 3'b000, 1'b1, 4'b0110, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[2]  = '{"sll",   5'b01100, 3'b001, 1'b0, 4'b1110, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[3]  = '{"slt",   5'b01100, 3'b010, 1'b0, 4'b0111, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[4]  = '{"sltu",  5'b01100, 3'b011, 1'b0, 4'b1001, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[5]  = '{"srl",   5'b01100, 3'b101, 1'b0, 4'b1101, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[6]  = '{"sra",   5'b01100, 3'b101, 1'b1, 4'b1111, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[7]  = '{"or",    5'b01100, 3'b110, 1'b0, 4'b0001, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[8]  = '{"and",   5'b01100, 3'b111, 1'b0, 4'b0000, 4, 1, 2'b00, 3'b000, 0, 0, 0, 2'b00};
    tbl[9]  = '{"srai",  5'b00100, 3'b101, 1'b1, 4'b1111, 4, 1, 2'b00, 3'b001, 0, 0, 0, 2'b00};
    tbl[10] = '{"slli",  5'b00100, 3'b001, 1'b0, 4'b1110, 4, 1, 2'b00, 3'b001, 0, 0, 0, 2'b00};
    tbl[11] = '{"addi7", 5'b00100, 3'b000, 1'b1, 4'b0010, 4, 1, 2'b00, 3'b001, 0, 0, 0, 2'b00};
    tbl[12] = '{"xori",  5'b00100, 3'b100, 1'b0, 4'b1100, 4, 1, 2'b00, 3'b001, 0, 0, 0, 2'b00};
    tbl[13] = '{"lw",    5'b00000, 3'b010, 1'b0, 4'b0010, 5, 1, 2'b01, 3'b001, 0, 0, 0, 2'b00};
    tbl[14] = '{"sw",    5'b01000, 3'b010, 1'b0, 4'b0010, 4, 0, 2'b00, 3'b010, 1, 0, 0, 2'b00};
    tbl[15] = '{"beq",   5'b11000, 3'b000, 1'b0, 4'b0000, 3, 0, 2'b00, 3'b011, 0, 1, 0, 2'b00};
    tbl[16] = '{"bne",   5'b11000, 3'b001, 1'b0, 4'b0000, 3, 0, 2'b00, 3'b011, 0, 1, 0, 2'b00};
    tbl[17] = '{"jal",   5'b11011, 3'b000, 1'b0, 4'b0000, 3, 1, 2'b10, 3'b100, 0, 0, 1, 2'b01};
    tbl[18] = '{"jalr",  5'b11001, 3'b000, 1'b0, 4'b0010, 3, 1, 2'b10, 3'b001, 0, 0, 1, 2'b10};
    tbl[19] = '{"lui",   5'b01101, 3'b000, 1'b0, 4'b0000, 3, 1, 2'b11, 3'b101, 0, 0, 0, 2'b00};
    tbl[20] = '{"auipc", 5'b00101, 3'b000, 1'b0, 4'b0010, 4, 1, 2'b00, 3'b101, 0, 0, 0, 2'b00};

    rst = 1'b1; OPcode = '0; Fun3 = '0; Fun7 = 1'b0; MIO_ready = 1'b0; cmp_taken = 1'b0;
    wait_left = 0; stuck = 0; exp_instret = 0;
    @(negedge clk);
    #1;
    push_exp("reset.ctl", 0);     pop_cmp(ctl);
    push_exp("reset.trap", 0);    pop_cmp({trap, trap_cause});
    push_exp("reset.instret", 0); pop_cmp(instret);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 21; i++) run_instr(tbl[i], 1'b1, 0);
    run_instr(tbl[15], 1'b0, 0);
    run_instr(tbl[13], 1'b0, 3);
    run_instr(tbl[14], 1'b0, 2);

    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 20);
      w = $urandom_range(0, 3);
      run_instr(tbl[k], 1'($urandom_range(0, 1)), w);
    end

    // Reset while a store is stalled in MEM.
    OPcode = 5'b01000; Fun3 = 3'b010; wait_left = 1000;
    m = 0;
    for (int c = 0; c < 10 && !m; c++) begin
      cycle_drive(m);
      if (!m) @(posedge clk);
    end
    push_exp("rstmem.reached_mem", 1); pop_cmp(m);
    rst = 1'b1;
    #1;
    push_exp("rstmem.memrw", 0);   pop_cmp(MemRW);
    push_exp("rstmem.cpu_mio", 0); pop_cmp(CPU_MIO);
    push_exp("rstmem.instret", 0); pop_cmp(instret);
    @(posedge clk);
    #1;
    push_exp("rstmem.ctl", 0);     pop_cmp(ctl);
    MIO_ready = 1'b0; wait_left = 0; exp_instret = 0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    push_exp("rstmem.fetch", 3'b100); pop_cmp({CPU_MIO, IorD, MemRW});
    run_instr(tbl[0], 1'b0, 0);

    run_illegal("illop", 5'b11111, 3'b000);
    run_illegal("illbr", 5'b11000, 3'b010);

    // MIO_ready stuck low during fetch.
    stuck = 1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      cycle_drive(m);
      if (!CPU_MIO) break;
      n++;
    end
    push_exp("timeout.cycles", 16); pop_cmp(n);
    push_exp("timeout.trap", 1);    pop_cmp(trap);
    push_exp("timeout.cause", 1);   pop_cmp(trap_cause);
    push_exp("timeout.ctl", 0);     pop_cmp(ctl);
    stuck = 0;
    do_reset();
    run_instr(tbl[13], 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
